// File: rtl/seg7_pkg.sv
// Shared 7-segment types and the active-high glyph table.
// Segment vector order is {a,b,c,d,e,f,g}, MSB = a.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'b0000000;

  // Lowercase b and d keep them distinct from 8 and 0.
  localparam seg_t GLYPH [0:15] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

endpackage

// File: rtl/hex_to_7seg_lut.sv
// Purely combinational nibble-to-glyph lookup, active-high (1 = lit).
module hex_to_7seg_lut
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output seg_t       glyph
);

  // Every nibble value has a glyph, so no default case is needed.
  assign glyph = GLYPH[nib];

endmodule

// File: rtl/hex_to_7seg_decoder.sv
// Registered hex-nibble to 7-segment driver with enable, blank and
// selectable output polarity.
// Optional decimal point: define SEG_DP_EN to add i_dp / o_dp.
module hex_to_7seg_decoder
  import seg7_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] in,
  input  logic       i_en,
  input  logic       i_blank,
`ifdef SEG_DP_EN
  input  logic       i_dp,
  output logic       o_dp,
`endif
  output logic       o_a,
  output logic       o_b,
  output logic       o_c,
  output logic       o_d,
  output logic       o_e,
  output logic       o_f,
  output logic       o_g
);

  // Polarity is folded in before the register so pins come straight off flops.
  localparam seg_t POL_MASK = ACTIVE_LOW ? 7'b1111111 : 7'b0000000;
  localparam seg_t SEG_DARK = SEG_OFF ^ POL_MASK;

  seg_t glyph;
  seg_t seg_nxt;
  seg_t seg_q;

  hex_to_7seg_lut u_lut (
    .nib   (in),
    .glyph (glyph)
  );

  // Blank overrides the glyph; inversion applies after so dark stays unlit.
  always_comb begin
    seg_nxt = (i_blank ? SEG_OFF : glyph) ^ POL_MASK;
  end

  // Segment register: reset wins, otherwise load only when enabled.
  always_ff @(posedge i_clk) begin
    if (i_rst)     seg_q <= SEG_DARK;
    else if (i_en) seg_q <= seg_nxt;
  end

  assign {o_a, o_b, o_c, o_d, o_e, o_f, o_g} = seg_q;

`ifdef SEG_DP_EN
  logic dp_q;

  // Decimal point follows the same reset/enable/blank/polarity rules.
  always_ff @(posedge i_clk) begin
    if (i_rst)     dp_q <= ACTIVE_LOW;
    else if (i_en) dp_q <= (i_dp & ~i_blank) ^ ACTIVE_LOW;
  end

  assign o_dp = dp_q;
`endif

endmodule

// File: tb/tb_hex_to_7seg_decoder.sv
// Scoreboard bench: driver pushes the reference model's expected state per
// edge, monitor pops and compares both polarity instances on the falling edge.
module tb_hex_to_7seg_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] nib = 4'd0;
  logic       en = 1'b0;
  logic       blank = 1'b0;
  logic       dp = 1'b0;

  logic [6:0] seg_h, seg_l;
  logic       dp_h, dp_l;

  int errors = 0;
  int checks = 0;
  int step_n = 0;

  // Expected active-high state: {seg[6:0], dp}
  logic [7:0] exp_q[$];

  // Glyphs written out straight from the display character chart.
  logic [6:0] chart [16];
  logic [6:0] m_seg;
  logic       m_dp;

  always #5 clk = ~clk;

  hex_to_7seg_decoder #(.ACTIVE_LOW(1'b0)) dut_h (
    .i_clk(clk), .i_rst(rst), .in(nib), .i_en(en), .i_blank(blank),
`ifdef SEG_DP_EN
    .i_dp(dp), .o_dp(dp_h),
`endif
    .o_a(seg_h[6]), .o_b(seg_h[5]), .o_c(seg_h[4]), .o_d(seg_h[3]),
    .o_e(seg_h[2]), .o_f(seg_h[1]), .o_g(seg_h[0])
  );

  hex_to_7seg_decoder #(.ACTIVE_LOW(1'b1)) dut_l (
    .i_clk(clk), .i_rst(rst), .in(nib), .i_en(en), .i_blank(blank),
`ifdef SEG_DP_EN
    .i_dp(dp), .o_dp(dp_l),
`endif
    .o_a(seg_l[6]), .o_b(seg_l[5]), .o_c(seg_l[4]), .o_d(seg_l[3]),
    .o_e(seg_l[2]), .o_f(seg_l[1]), .o_g(seg_l[0])
  );

`ifndef SEG_DP_EN
  assign dp_h = 1'b0;
  assign dp_l = 1'b1;
`endif

  // Drive one cycle of inputs, advance the model, queue its expectation.
  task automatic step(input bit r, input bit e, input bit b, input logic [3:0] n, input bit d);
    rst = r; en = e; blank = b; nib = n; dp = d;
    if (r) begin
      m_seg = 7'b0;
      m_dp  = 1'b0;
    end else if (e) begin
      m_seg = b ? 7'b0 : chart[n];
      m_dp  = d && !b;
    end
    exp_q.push_back({m_seg, m_dp});
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are valid every cycle after the edge.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        step_n++;
        checks++;
        if (seg_h !== e[7:1]) begin
          errors++;
          $display("FAIL seg_active_high cycle=%0d got=%b exp=%b", step_n, seg_h, e[7:1]);
        end
        checks++;
        if (seg_l !== ~e[7:1]) begin
          errors++;
          $display("FAIL seg_active_low cycle=%0d got=%b exp=%b", step_n, seg_l, ~e[7:1]);
        end
`ifdef SEG_DP_EN
        checks++;
        if (dp_h !== e[0] || dp_l !== ~e[0]) begin
          errors++;
          $display("FAIL dp cycle=%0d got=%b/%b exp=%b/%b", step_n, dp_h, dp_l, e[0], ~e[0]);
        end
`endif
      end
    end
  end

  initial begin
    chart = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
              7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
              7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
              7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    m_seg = 7'b0;
    m_dp  = 1'b0;

    // Reset overrides enable with a lit-everything nibble.
    step(1, 1, 0, 4'd8, 1);
    step(1, 1, 1, 4'd8, 1);
    // Sweep every nibble.
    for (int i = 0; i < 16; i++) step(0, 1, 0, 4'(i), i[0]);
    // Hold: enable low freezes, blank ignored while disabled.
    step(0, 1, 0, 4'd3, 0);
    step(0, 0, 0, 4'd7, 1);
    step(0, 0, 1, 4'd7, 1);
    step(0, 1, 0, 4'd7, 0);
    // Blank then release.
    step(0, 1, 1, 4'd8, 1);
    step(0, 1, 0, 4'd8, 1);
    // Polarity spot values and decimal point with a glyph.
    step(0, 1, 0, 4'd1, 0);
    step(0, 1, 0, 4'd2, 1);
    step(0, 1, 1, 4'd2, 1);
    // Reset mid-operation, then first enabled edge loads current nibble.
    step(1, 0, 0, 4'hA, 1);
    step(0, 0, 0, 4'hA, 1);
    step(0, 1, 0, 4'hA, 1);
    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      step($urandom_range(19) == 0, $urandom_range(3) != 0,
           $urandom_range(4) == 0, 4'($urandom), 1'($urandom));
    en = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
